// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the framed program loader:
// FSM state encoding, frame result codes and the default start byte.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN    = 3'd1,
    DATA   = 3'd2,
    SUM    = 3'd3,
    COMMIT = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_SUM     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

endpackage

// File: rtl/prog_loader_if.sv
// Host byte link into the program loader: one byte per valid/ready transfer.
interface prog_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/prog_loader_timeout.sv
// Inter-byte gap counter. Restarts on every transfer, advances only while a
// frame is open, and flags the cycle whose edge would complete the full
// TIMEOUT_CYCLES idle gap. Only built when PROG_LOADER_TIMEOUT_EN is defined.
module prog_loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;

  // Count idle cycles inside a frame, saturating at the full gap length
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (count_en && (r_cnt != FULL)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = count_en && (r_cnt == LAST);

endmodule

// File: rtl/prog_loader.sv
// Framed program loader: MAGIC / length / payload / checksum frames from a
// host byte link are streamed into the controller program port, and the
// controller is held (core_hold) until a frame passes its checksum.
// Optional feature macro: PROG_LOADER_TIMEOUT_EN enables the inter-byte
// timeout (err_code 11); without it a stalled frame waits indefinitely.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  MAGIC          = DEFAULT_MAGIC
) (
  input  logic          clock,
  input  logic          rst_n,
  prog_loader_if.slave  link,
  output logic          prog_enable,
  output logic [7:0]    prog_data,
  output logic          core_hold,
  output logic          loaded,
  output logic          error,
  output logic [1:0]    err_code
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     r_state;
  logic       r_in_ready;
  logic       r_prog_en;
  logic [7:0] r_prog_data;
  logic       r_hold;
  logic       r_loaded;
  logic       r_error;
  logic [1:0] r_err_code;
  logic [7:0] r_sum;
  logic [7:0] r_remaining;
  logic       r_pass;

  logic       w_hs;
  logic [7:0] w_sum_next;
  logic       w_len_bad;
  logic       w_expired;
  logic       w_timeout_fail;

  assign w_hs       = link.in_valid && r_in_ready;
  assign w_sum_next = r_sum + link.in_data;
  assign w_len_bad  = (link.in_data == 8'd0) || (link.in_data > MAX_LEN_B);

`ifdef PROG_LOADER_TIMEOUT_EN
  logic w_counting;
  assign w_counting = (r_state == LEN) || (r_state == DATA) || (r_state == SUM);

  prog_loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock    (clock),
    .rst_n    (rst_n),
    .clear    (w_hs),
    .count_en (w_counting),
    .expired  (w_expired)
  );
`else
  assign w_expired = 1'b0;
  // TIMEOUT_CYCLES only sizes the gap counter; keep it referenced here.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  // A byte landing on the expiry edge takes precedence over the timeout
  assign w_timeout_fail = w_expired && !w_hs;

  // Frame FSM with registered handshake, program-port and status outputs
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_prog_en   <= 1'b0;
      r_prog_data <= 8'h00;
      r_hold      <= 1'b1;
      r_loaded    <= 1'b0;
      r_error     <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_sum       <= 8'h00;
      r_remaining <= 8'h00;
      r_pass      <= 1'b0;
    end else begin
      r_prog_en <= 1'b0;
      if (w_timeout_fail) begin
        r_state    <= IDLE;
        r_in_ready <= 1'b1;
        r_loaded   <= 1'b0;
        r_error    <= 1'b1;
        r_err_code <= ERR_TIMEOUT;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_hs && (link.in_data == MAGIC)) begin
              r_state  <= LEN;
              r_hold   <= 1'b1;
              r_loaded <= 1'b0;
            end
          end
          LEN: begin
            if (w_hs) begin
              if (w_len_bad) begin
                r_state    <= IDLE;
                r_loaded   <= 1'b0;
                r_error    <= 1'b1;
                r_err_code <= ERR_LEN;
              end else begin
                r_sum       <= 8'h00;
                r_remaining <= link.in_data;
                r_state     <= DATA;
              end
            end
          end
          DATA: begin
            if (w_hs) begin
              r_prog_en   <= 1'b1;
              r_prog_data <= link.in_data;
              r_sum       <= w_sum_next;
              r_remaining <= r_remaining - 8'd1;
              if (r_remaining == 8'd1) begin
                r_state <= SUM;
              end
            end
          end
          SUM: begin
            if (w_hs) begin
              r_pass     <= (w_sum_next == 8'h00);
              r_state    <= COMMIT;
              r_in_ready <= 1'b0;
            end
          end
          COMMIT: begin
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
            if (r_pass) begin
              r_loaded   <= 1'b1;
              r_error    <= 1'b0;
              r_err_code <= ERR_NONE;
              r_hold     <= 1'b0;
            end else begin
              r_loaded   <= 1'b0;
              r_error    <= 1'b1;
              r_err_code <= ERR_SUM;
              r_hold     <= 1'b1;
            end
          end
          default: begin
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign link.in_ready = r_in_ready;
  assign prog_enable   = r_prog_en;
  assign prog_data     = r_prog_data;
  assign core_hold     = r_hold;
  assign loaded        = r_loaded;
  assign error         = r_error;
  assign err_code      = r_err_code;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: per-cycle vector table for the frame
// scenarios, plus hand-written timeout and asynchronous-reset sequences.
module tb_prog_loader;

  localparam int unsigned T = 16;

  logic       clock;
  logic       rst_n;
  logic       prog_enable;
  logic [7:0] prog_data;
  logic       core_hold;
  logic       loaded;
  logic       error;
  logic [1:0] err_code;

  prog_loader_if link ();

  prog_loader #(
    .MAX_LEN        (64),
    .TIMEOUT_CYCLES (T),
    .MAGIC          (8'hA5)
  ) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .link        (link.slave),
    .prog_enable (prog_enable),
    .prog_data   (prog_data),
    .core_hold   (core_hold),
    .loaded      (loaded),
    .error       (error),
    .err_code    (err_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       en;
    logic [7:0] pd;
    logic       hold;
    logic       ld;
    logic       er;
    logic [1:0] ec;
    logic       rdy;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic v, input logic [7:0] d, input logic en,
                     input logic [7:0] pd, input logic hold, input logic ld,
                     input logic er, input logic [1:0] ec, input logic rdy);
    vec_t e;
    e.v = v; e.d = d; e.en = en; e.pd = pd; e.hold = hold;
    e.ld = ld; e.er = er; e.ec = ec; e.rdy = rdy;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic en, input logic [7:0] pd,
                           input logic hold, input logic ld, input logic er,
                           input logic [1:0] ec, input logic rdy);
    chk({tag, ".prog_enable"}, {7'd0, prog_enable}, {7'd0, en});
    if (en) chk({tag, ".prog_data"}, prog_data, pd);
    chk({tag, ".core_hold"}, {7'd0, core_hold}, {7'd0, hold});
    chk({tag, ".loaded"},    {7'd0, loaded},    {7'd0, ld});
    chk({tag, ".error"},     {7'd0, error},     {7'd0, er});
    chk({tag, ".err_code"},  {6'd0, err_code},  {6'd0, ec});
    chk({tag, ".in_ready"},  {7'd0, link.in_ready}, {7'd0, rdy});
  endtask

  // Called at posedge+1: drive inputs for one cycle and advance to next posedge+1.
  task automatic cycle(input logic v, input logic [7:0] d);
    link.in_valid = v;
    link.in_data  = d;
    @(posedge clock);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    link.in_valid = 1'b0;
    link.in_data  = 8'h00;

    // Good frame A5 03 11 22 33 9A; a MAGIC offered during COMMIT is refused
    add(1, 8'hA5, 0, 8'h00, 1, 0, 0, 2'd0, 1);
    add(1, 8'h03, 0, 8'h00, 1, 0, 0, 2'd0, 1);
    add(1, 8'h11, 1, 8'h11, 1, 0, 0, 2'd0, 1);
    add(1, 8'h22, 1, 8'h22, 1, 0, 0, 2'd0, 1);
    add(1, 8'h33, 1, 8'h33, 1, 0, 0, 2'd0, 1);
    add(1, 8'h9A, 0, 8'h00, 1, 0, 0, 2'd0, 0);
    add(1, 8'hA5, 0, 8'h00, 0, 1, 0, 2'd0, 1);
    // Bad checksum A5 03 11 22 33 9B
    add(1, 8'hA5, 0, 8'h00, 1, 0, 0, 2'd0, 1);
    add(1, 8'h03, 0, 8'h00, 1, 0, 0, 2'd0, 1);
    add(1, 8'h11, 1, 8'h11, 1, 0, 0, 2'd0, 1);
    add(1, 8'h22, 1, 8'h22, 1, 0, 0, 2'd0, 1);
    add(1, 8'h33, 1, 8'h33, 1, 0, 0, 2'd0, 1);
    add(1, 8'h9B, 0, 8'h00, 1, 0, 0, 2'd0, 0);
    add(0, 8'h00, 0, 8'h00, 1, 0, 1, 2'd2, 1);
    // Length 0x41 > 64 fails with code 01 on the LEN edge
    add(1, 8'hA5, 0, 8'h00, 1, 0, 1, 2'd2, 1);
    add(1, 8'h41, 0, 8'h00, 1, 0, 1, 2'd1, 1);
    // Length 0 fails; following bytes are dropped in IDLE
    add(1, 8'hA5, 0, 8'h00, 1, 0, 1, 2'd1, 1);
    add(1, 8'h00, 0, 8'h00, 1, 0, 1, 2'd1, 1);
    add(1, 8'h11, 0, 8'h00, 1, 0, 1, 2'd1, 1);
    add(1, 8'h22, 0, 8'h00, 1, 0, 1, 2'd1, 1);
    // Garbage 00 FF 5A, then a good frame with a one-cycle gap in DATA
    add(1, 8'h00, 0, 8'h00, 1, 0, 1, 2'd1, 1);
    add(1, 8'hFF, 0, 8'h00, 1, 0, 1, 2'd1, 1);
    add(1, 8'h5A, 0, 8'h00, 1, 0, 1, 2'd1, 1);
    add(1, 8'hA5, 0, 8'h00, 1, 0, 1, 2'd1, 1);
    add(1, 8'h03, 0, 8'h00, 1, 0, 1, 2'd1, 1);
    add(1, 8'h11, 1, 8'h11, 1, 0, 1, 2'd1, 1);
    add(0, 8'h77, 0, 8'h00, 1, 0, 1, 2'd1, 1);
    add(1, 8'h22, 1, 8'h22, 1, 0, 1, 2'd1, 1);
    add(1, 8'h33, 1, 8'h33, 1, 0, 1, 2'd1, 1);
    add(1, 8'h9A, 0, 8'h00, 1, 0, 1, 2'd1, 0);
    add(0, 8'h00, 0, 8'h00, 0, 1, 0, 2'd0, 1);
    // MAGIC inside the payload is plain data: A5 02 A5 01 5A
    add(1, 8'hA5, 0, 8'h00, 1, 0, 0, 2'd0, 1);
    add(1, 8'h02, 0, 8'h00, 1, 0, 0, 2'd0, 1);
    add(1, 8'hA5, 1, 8'hA5, 1, 0, 0, 2'd0, 1);
    add(1, 8'h01, 1, 8'h01, 1, 0, 0, 2'd0, 1);
    add(1, 8'h5A, 0, 8'h00, 1, 0, 0, 2'd0, 0);
    add(0, 8'h00, 0, 8'h00, 0, 1, 0, 2'd0, 1);

    repeat (3) @(posedge clock);
    #1;
    chk("reset.prog_data", prog_data, 8'h00);
    check_all("reset", 0, 8'h00, 1, 0, 0, 2'd0, 1);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].v, tbl[i].d);
      check_all($sformatf("vec%0d", i), tbl[i].en, tbl[i].pd, tbl[i].hold,
                tbl[i].ld, tbl[i].er, tbl[i].ec, tbl[i].rdy);
    end

`ifdef PROG_LOADER_TIMEOUT_EN
    // Byte arriving on the expiry edge wins: A5 02 11, T-1 idle, 22 CD
    cycle(1, 8'hA5); cycle(1, 8'h02); cycle(1, 8'h11);
    repeat (T - 1) cycle(0, 8'h00);
    check_all("to_edge_idle", 0, 8'h00, 1, 0, 0, 2'd0, 1);
    cycle(1, 8'h22);
    check_all("to_edge_byte", 1, 8'h22, 1, 0, 0, 2'd0, 1);
    cycle(1, 8'hCD);
    cycle(0, 8'h00);
    check_all("to_edge_done", 0, 8'h00, 0, 1, 0, 2'd0, 1);
    // Full gap of T idle cycles: code 11, back in IDLE
    cycle(1, 8'hA5); cycle(1, 8'h02); cycle(1, 8'h11);
    repeat (T) cycle(0, 8'h00);
    check_all("timeout", 0, 8'h00, 1, 0, 1, 2'd3, 1);
    cycle(1, 8'h22);
    check_all("timeout_idle", 0, 8'h00, 1, 0, 1, 2'd3, 1);
`else
    // No timeout built: a long stall, then 22 CD completes the frame
    cycle(1, 8'hA5); cycle(1, 8'h02); cycle(1, 8'h11);
    repeat (T + 4) cycle(0, 8'h00);
    check_all("stall", 0, 8'h00, 1, 0, 0, 2'd0, 1);
    cycle(1, 8'h22);
    check_all("stall_byte", 1, 8'h22, 1, 0, 0, 2'd0, 1);
    cycle(1, 8'hCD);
    check_all("stall_sum", 0, 8'h00, 1, 0, 0, 2'd0, 0);
    cycle(0, 8'h00);
    check_all("stall_done", 0, 8'h00, 0, 1, 0, 2'd0, 1);
`endif

    // Reset mid-DATA while a strobe is high clears everything at once
    cycle(1, 8'hA5); cycle(1, 8'h04); cycle(1, 8'h01);
    check_all("pre_reset", 1, 8'h01, 1, 0, error, err_code, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset.prog_data", prog_data, 8'h00);
    check_all("async_reset", 0, 8'h00, 1, 0, 0, 2'd0, 1);
    link.in_valid = 1'b0;
    @(posedge clock);
    #1 rst_n = 1'b1;
    cycle(1, 8'hA5); cycle(1, 8'h03);
    cycle(1, 8'h11);
    check_all("post_reset_b0", 1, 8'h11, 1, 0, 0, 2'd0, 1);
    cycle(1, 8'h22);
    check_all("post_reset_b1", 1, 8'h22, 1, 0, 0, 2'd0, 1);
    cycle(1, 8'h33);
    check_all("post_reset_b2", 1, 8'h33, 1, 0, 0, 2'd0, 1);
    cycle(1, 8'h9A);
    cycle(0, 8'h00);
    check_all("post_reset_done", 0, 8'h00, 0, 1, 0, 2'd0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
